fwrisc_mem_responder: RTL
=========================

// Module: fwrisc_mem_responder
// PURPOSE
//  Target (responder) end of the fwrisc instruction and data buses. Serves ifetch
//  and load/store requests from a unified word-organised RAM. Each port has its own
//  wait-state counter and FSM. Used as the on-chip memory of fwrisc SoC and test
//  benches; flags out-of-range accesses.
// PARAMETERS
//  MEM_WORDS  4096          RAM depth in 32-bit words (power of 2)
//  BASE_ADDR  32'h80000000  byte address of word 0
//  I_WAIT     0             extra wait cycles on instruction port (0..15)
//  D_WAIT     1             extra wait cycles on data port (0..15)
// PORTS
//  clock    in   1   clock, all logic on posedge
//  reset    in   1   asynchronous, active-low reset
//  iaddr    in   32  fetch byte address, [1:0] ignored
//  ivalid   in   1   fetch request, held by core until iready
//  idata    out  32  fetch data, valid while iready=1
//  iready   out  1   fetch complete, one-cycle pulse
//  daddr    in   32  data byte address, [1:0] ignored
//  dwdata   in   32  store data, lane-replicated by core
//  dstrb    in   4   byte-lane enables for stores
//  dwrite   in   1   1=store, 0=load; qualified by dvalid
//  dvalid   in   1   data request, held by core until dready
//  drdata   out  32  load data (full word), valid while dready=1
//  dready   out  1   data complete, one-cycle pulse
//  err      out  1   sticky: an out-of-range access was seen
//  err_addr out  32  byte address of first out-of-range access
// BEHAVIOUR
//  Reset (reset=0, async): iready=0, dready=0, idata=0, drdata=0, err=0, err_addr=0.
//  - Both FSMs go to IDLE. RAM contents are not cleared.
//  Per-port FSM, same for I and D (X=I_WAIT/D_WAIT):
//  - IDLE: valid=1 -> latch word index, cnt<=X; go to WAIT if X>0, else to ACK.
//  - WAIT: cnt decrements; cnt==1 -> ACK. valid=0 in WAIT aborts to IDLE:
//    no ready, no write.
//  - ACK: ready=1 (registered) for exactly one cycle, then IDLE. Data output is
//    registered on entry to ACK.
//  - Latency: ready is asserted X+1 cycles after the first cycle valid=1 is sampled.
//  - Minimum of one IDLE cycle between transactions on the same port.
//  Address decode:
//  - In range iff BASE_ADDR <= addr < BASE_ADDR+4*MEM_WORDS.
//  - Index = (addr-BASE_ADDR)>>2, $clog2(MEM_WORDS) bits.
//  Reads:
//  - idata/drdata take mem[index] on the ACK entry edge. They hold their value
//    after ACK until the next ACK.
//  - Out-of-range read returns 32'h0.
//  Stores:
//  - Occur on the ACK cycle edge. Only lanes with dstrb[n]=1 are written,
//    byte n = dwdata[8n+7:8n].
//  - drdata on a store = pre-write word contents.
//  - Out-of-range store: no RAM write, ACK still given.
//  - dstrb=0 store completes with no RAM change.
//  Error:
//  - On any out-of-range ACK, err<=1.
//  - err_addr is captured only if err was 0. If I and D hit in the same cycle,
//    the D address wins.
//  - err is cleared only by reset.
//  Collision:
//  - D store and I fetch to the same word in the same ACK cycle: fetch returns
//    the old word (read-before-write).
//  - Both ports proceed independently; no arbitration stalls.
//  Reset mid-transaction:
//  - Ready is forced low immediately and the FSM returns to IDLE.
//  - No partial store: a store is written only on the ACK edge.
// TESTING
//  1 I_WAIT=0, preload mem[0]=32'h00000013. Hold ivalid=1, iaddr=BASE_ADDR
//    -> iready=1 on the 2nd cycle, idata=32'h00000013.
//  2 D_WAIT=1, store daddr=BASE+8, dwdata=32'hAABBCCDD, dstrb=4'b0100 on a word
//    preloaded 0 -> dready on cycle 3; later load returns 32'h00BB0000.
//  3 Store and fetch to same word in the same ACK cycle -> idata = old value;
//    next fetch sees new value.
//  4 Load daddr=32'h00000010 (out of range) -> dready pulses, drdata=0, err=1,
//    err_addr=32'h00000010; 2nd bad access leaves err_addr unchanged.
//  5 D_WAIT=3, drop dvalid in WAIT -> no dready, RAM unchanged. Separately,
//    reset=0 mid-WAIT -> dready=0 at once, FSM IDLE.
//  6 Back-to-back: 100 random fetches/loads/stores against a scoreboard model
//    -> all data match, each ready is one cycle long.

Source files
------------

// File: rtl/fwrisc_mem_responder_if.sv
// Bus bundle between a fwrisc core (master) and its on-chip memory (slave).
//  iaddr/ivalid        -> fetch request      idata/iready        <- fetch response
//  daddr/dwdata/dstrb/
//  dwrite/dvalid       -> load/store request drdata/dready       <- data response
//  err/err_addr        <- sticky out-of-range flag and first offending address
interface fwrisc_mem_responder_if;
    logic [31:0] iaddr;
    logic        ivalid;
    logic [31:0] idata;
    logic        iready;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dstrb;
    logic        dwrite;
    logic        dvalid;
    logic [31:0] drdata;
    logic        dready;
    logic        err;
    logic [31:0] err_addr;

    modport master (
        output iaddr, ivalid, daddr, dwdata, dstrb, dwrite, dvalid,
        input  idata, iready, drdata, dready, err, err_addr
    );

    modport slave (
        input  iaddr, ivalid, daddr, dwdata, dstrb, dwrite, dvalid,
        output idata, iready, drdata, dready, err, err_addr
    );
endinterface

// File: rtl/fwrisc_mem_responder.sv
// Responder for the fwrisc instruction and data buses, backed by one
// word-organised RAM. Each port runs its own wait-state FSM; out-of-range
// accesses are acknowledged and flagged through a sticky error.
//  clock : clock, all logic on posedge
//  reset : asynchronous active-low reset
//  bus   : slave side of fwrisc_mem_responder_if (fetch, load/store, error)
module fwrisc_mem_responder #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned I_WAIT    = 0,
    parameter int unsigned D_WAIT    = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    fwrisc_mem_responder_if.slave        bus
);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [32:0] LIMIT = 33'(BASE_ADDR) + 33'(4 * MEM_WORDS);
    localparam logic [3:0]  I_CNT = 4'(I_WAIT);
    localparam logic [3:0]  D_CNT = 4'(D_WAIT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [31:0] mem [MEM_WORDS];

    logic [1:0]       i_state_q, i_state_d;
    logic [3:0]       i_cnt_q, i_cnt_d;
    logic [31:0]      i_addr_q, i_addr_d;
    logic             iready_q, iready_d;
    logic [31:0]      idata_q, idata_d;

    logic [1:0]       d_state_q, d_state_d;
    logic [3:0]       d_cnt_q, d_cnt_d;
    logic [31:0]      d_addr_q, d_addr_d;
    logic             dready_q, dready_d;
    logic [31:0]      drdata_q, drdata_d;

    logic             err_q, err_d;
    logic [31:0]      err_addr_q, err_addr_d;

    logic [31:0]      i_addr_c, d_addr_c, i_off_c, d_off_c;
    logic [IDX_W-1:0] i_idx_c, d_idx_c;
    logic             i_inr_c, d_inr_c, i_fire_c, d_fire_c;
    logic             unused_c;

    function automatic logic in_range(input logic [31:0] a);
        return ({1'b0, a} >= 33'(BASE_ADDR)) && ({1'b0, a} < LIMIT);
    endfunction

    // In IDLE the request is accepted this edge, so decode the live address;
    // afterwards use the address latched at acceptance.
    always_comb begin
        i_addr_c = (i_state_q == ST_IDLE) ? bus.iaddr : i_addr_q;
        d_addr_c = (d_state_q == ST_IDLE) ? bus.daddr : d_addr_q;
        i_off_c  = i_addr_c - BASE_ADDR;
        d_off_c  = d_addr_c - BASE_ADDR;
        i_idx_c  = i_off_c[IDX_W+1:2];
        d_idx_c  = d_off_c[IDX_W+1:2];
        i_inr_c  = in_range(i_addr_c);
        d_inr_c  = in_range(d_addr_c);
    end

    assign unused_c = ^{i_off_c, d_off_c};

    // Instruction port FSM; data is captured on the edge that enters ACK.
    always_comb begin
        i_state_d = i_state_q;
        i_cnt_d   = i_cnt_q;
        i_addr_d  = i_addr_q;
        idata_d   = idata_q;
        case (i_state_q)
            ST_IDLE: begin
                if (bus.ivalid) begin
                    i_addr_d  = bus.iaddr;
                    i_cnt_d   = I_CNT;
                    i_state_d = (I_CNT == 4'd0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!bus.ivalid)            i_state_d = ST_IDLE;
                else if (i_cnt_q == 4'd1)   i_state_d = ST_ACK;
                else                        i_cnt_d   = i_cnt_q - 4'd1;
            end
            ST_ACK:  i_state_d = ST_IDLE;
            default: i_state_d = ST_IDLE;
        endcase
        i_fire_c = (i_state_d == ST_ACK);
        iready_d = i_fire_c;
        if (i_fire_c) idata_d = i_inr_c ? mem[i_idx_c] : 32'h0;
    end

    // Data port FSM; drdata is the pre-write word, also for stores.
    always_comb begin
        d_state_d = d_state_q;
        d_cnt_d   = d_cnt_q;
        d_addr_d  = d_addr_q;
        drdata_d  = drdata_q;
        case (d_state_q)
            ST_IDLE: begin
                if (bus.dvalid) begin
                    d_addr_d  = bus.daddr;
                    d_cnt_d   = D_CNT;
                    d_state_d = (D_CNT == 4'd0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!bus.dvalid)            d_state_d = ST_IDLE;
                else if (d_cnt_q == 4'd1)   d_state_d = ST_ACK;
                else                        d_cnt_d   = d_cnt_q - 4'd1;
            end
            ST_ACK:  d_state_d = ST_IDLE;
            default: d_state_d = ST_IDLE;
        endcase
        d_fire_c = (d_state_d == ST_ACK);
        dready_d = d_fire_c;
        if (d_fire_c) drdata_d = d_inr_c ? mem[d_idx_c] : 32'h0;
    end

    // Sticky error; the data port is evaluated last so it wins a same-cycle tie.
    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (i_fire_c && !i_inr_c) begin
            err_d = 1'b1;
            if (!err_q) err_addr_d = i_addr_c;
        end
        if (d_fire_c && !d_inr_c) begin
            err_d = 1'b1;
            if (!err_q) err_addr_d = d_addr_c;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i_state_q  <= ST_IDLE;
            i_cnt_q    <= 4'd0;
            i_addr_q   <= 32'h0;
            iready_q   <= 1'b0;
            idata_q    <= 32'h0;
            d_state_q  <= ST_IDLE;
            d_cnt_q    <= 4'd0;
            d_addr_q   <= 32'h0;
            dready_q   <= 1'b0;
            drdata_q   <= 32'h0;
            err_q      <= 1'b0;
            err_addr_q <= 32'h0;
        end else begin
            i_state_q  <= i_state_d;
            i_cnt_q    <= i_cnt_d;
            i_addr_q   <= i_addr_d;
            iready_q   <= iready_d;
            idata_q    <= idata_d;
            d_state_q  <= d_state_d;
            d_cnt_q    <= d_cnt_d;
            d_addr_q   <= d_addr_d;
            dready_q   <= dready_d;
            drdata_q   <= drdata_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // RAM write on the ACK-entry edge; reads above see the old word.
    always_ff @(posedge clock) begin
        if (d_fire_c && d_inr_c && bus.dwrite) begin
            for (int n = 0; n < 4; n++) begin
                if (bus.dstrb[n]) mem[d_idx_c][8*n +: 8] <= bus.dwdata[8*n +: 8];
            end
        end
    end

    assign bus.iready   = iready_q;
    assign bus.idata    = idata_q;
    assign bus.dready   = dready_q;
    assign bus.drdata   = drdata_q;
    assign bus.err      = err_q;
    assign bus.err_addr = err_addr_q;
endmodule
